mem_access_stage: RTL and testbench

MEM stage of the 5-stage MIPS pipeline. It sits directly downstream of EXECUTE and consumes the EX/MEM outputs: wb_ctlout, branch, memread, memwrite, zero, alu_result, rdata2out and five_bit_muxout.
- Contains the word-addressed data memory.
- Models a configurable multi-cycle memory latency and stalls upstream while an access is in flight.
- Drives the branch-taken decision.
- Registers the MEM/WB pipeline register for the writeback stage.

---
 rtl/mem_access_stage_if.sv | 38 +++
 rtl/mem_access_stage.sv | 110 +++++++++++
 tb/tb_mem_access_stage.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// EX/MEM inputs and MEM/WB outputs of the MEM stage; misaligned exists only with MEM_MISALIGN_TRAP_EN.
// master = EXECUTE/writeback side, slave = mem_access_stage.
interface mem_access_stage_if;
   logic [1:0]  wb_ctl;
   logic        branch;
   logic        memread;
   logic        memwrite;
   logic        zero;
   logic [31:0] alu_result;
   logic [31:0] rdata2;
   logic [4:0]  five_bit_muxout;

   logic        PCSrc;
   logic        mem_stall;
   logic [1:0]  wb_ctlout;
   logic [31:0] read_data;
   logic [31:0] mem_alu_result;
   logic [4:0]  mem_write_reg;
`ifdef MEM_MISALIGN_TRAP_EN
   logic        misaligned;
`endif

   modport master (
      output wb_ctl, branch, memread, memwrite, zero, alu_result, rdata2, five_bit_muxout,
      input  PCSrc, mem_stall, wb_ctlout, read_data, mem_alu_result, mem_write_reg
`ifdef MEM_MISALIGN_TRAP_EN
      , input misaligned
`endif
   );

   modport slave (
      input  wb_ctl, branch, memread, memwrite, zero, alu_result, rdata2, five_bit_muxout,
      output PCSrc, mem_stall, wb_ctlout, read_data, mem_alu_result, mem_write_reg
`ifdef MEM_MISALIGN_TRAP_EN
      , output misaligned
`endif
   );
endinterface

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: word data memory, branch decision, MEM/WB register; MEM_MISALIGN_TRAP_EN adds a misalignment trap.
// Latency 1 cycle, loads/stores 1+WAIT_CYCLES; mem_stall holds EX/MEM upstream while an access is in flight.
module mem_access_stage #(
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2
) (
   input logic              clk,
   input logic              reset,
   mem_access_stage_if.slave bus
);
   localparam int         AW       = $clog2(DEPTH);
   localparam bit         HAS_WAIT = (WAIT_CYCLES != 0);
   localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t      state, state_n;
   logic [3:0]  cnt, cnt_n;
   logic        stall_raw;
   logic        complete;
   logic        access;
   logic        store_en;
   logic [AW-1:0] idx;
   logic [31:0] load_dat;
   logic [1:0]  wb_next;
   logic [31:0] mem [DEPTH];
   logic        unused_addr_bits;

   assign idx              = bus.alu_result[AW+1:2];
   assign unused_addr_bits = ^{bus.alu_result[31:AW+2], bus.alu_result[1:0]};
   assign access           = bus.memread | bus.memwrite;
   assign bus.PCSrc        = bus.branch & bus.zero;
   assign bus.mem_stall    = reset & stall_raw;
   assign complete         = reset & ~stall_raw;

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      stall_raw = 1'b0;
      case (state)
         IDLE: begin
            if (access && HAS_WAIT) begin
               stall_raw = 1'b1;
               state_n   = WAIT;
               cnt_n     = CNT_LOAD;
            end
         end
         WAIT: begin
            if (cnt != 4'd0) begin
               stall_raw = 1'b1;
               cnt_n     = cnt - 4'd1;
            end else begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

`ifdef MEM_MISALIGN_TRAP_EN
   logic mis;
   assign mis      = access & (|bus.alu_result[1:0]);
   assign store_en = bus.memwrite & ~mis;
   assign load_dat = (bus.memread & ~mis) ? mem[idx] : 32'h0;
   assign wb_next  = {bus.wb_ctl[1] & ~(bus.memread & mis), bus.wb_ctl[0]};

   always_ff @(posedge clk) begin
      if (!reset)
         bus.misaligned <= 1'b0;
      else if (complete && mis)
         bus.misaligned <= 1'b1;
   end
`else
   assign store_en = bus.memwrite;
   assign load_dat = bus.memread ? mem[idx] : 32'h0;
   assign wb_next  = bus.wb_ctl;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // Array has no reset; load_dat samples it before this edge's write (read-before-write).
   always_ff @(posedge clk) begin
      if (complete && store_en)
         mem[idx] <= bus.rdata2;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         bus.wb_ctlout      <= 2'b00;
         bus.read_data      <= 32'h0;
         bus.mem_alu_result <= 32'h0;
         bus.mem_write_reg  <= 5'd0;
      end else if (stall_raw) begin
         bus.wb_ctlout <= 2'b00;
      end else begin
         bus.wb_ctlout      <= wb_next;
         bus.read_data      <= load_dat;
         bus.mem_alu_result <= bus.alu_result;
         bus.mem_write_reg  <= bus.five_bit_muxout;
      end
   end
endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboarded bench for mem_access_stage (DEPTH=256, WAIT_CYCLES=2) with a reference memory model.
module tb_mem_access_stage;
   localparam int WAITC = 2;

   logic clk;
   logic reset;
   mem_access_stage_if bus();

   mem_access_stage #(.DEPTH(256), .WAIT_CYCLES(WAITC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  wb;
      logic [31:0] rd;
      logic [31:0] alu;
      logic [4:0]  wr;
   } exp_t;

   exp_t        sbq[$];
   logic [31:0] model [256];
   int          vectors;
   int          miscompares;

   // Drives one instruction, predicts its result, waits for completion and checks it.
   task automatic issue(input logic [1:0] wb, input logic rd_en, input logic wr_en,
                        input logic [31:0] addr, input logic [31:0] wdat, input logic [4:0] rg);
      exp_t        e, got;
      logic [7:0]  mi;
      int          stalls;
      int          exp_stalls;
      bit          done;
      bus.wb_ctl          = wb;
      bus.memread         = rd_en;
      bus.memwrite        = wr_en;
      bus.alu_result      = addr;
      bus.rdata2          = wdat;
      bus.five_bit_muxout = rg;
      mi    = addr[9:2];
      e.wb  = wb;
      e.rd  = rd_en ? model[mi] : 32'h0;
      e.alu = addr;
      e.wr  = rg;
      sbq.push_back(e);
      if (wr_en) model[mi] = wdat;
      exp_stalls = (rd_en | wr_en) ? WAITC : 0;
      stalls = 0;
      done   = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (!bus.mem_stall) begin
            done = 1'b1;
         end else begin
            stalls++;
            @(posedge clk); #1;
            vectors++;
            if (bus.wb_ctlout !== 2'b00) begin
               miscompares++;
               $display("FAIL stall_bubble addr=%h: wb_ctlout=%b, required 00", addr, bus.wb_ctlout);
            end
         end
      end
      vectors++;
      if (!done || stalls != exp_stalls) begin
         miscompares++;
         $display("FAIL stall_count addr=%h: %0d stall cycles (done=%0d), required %0d", addr, stalls, done, exp_stalls);
      end
      @(posedge clk); #1;
      got.wb  = bus.wb_ctlout;
      got.rd  = bus.read_data;
      got.alu = bus.mem_alu_result;
      got.wr  = bus.mem_write_reg;
      e = sbq.pop_front();
      vectors++;
      if (got !== e) begin
         miscompares++;
         $display("FAIL mem_wb addr=%h: wb=%b rd=%h alu=%h wr=%0d, required wb=%b rd=%h alu=%h wr=%0d",
                  addr, got.wb, got.rd, got.alu, got.wr, e.wb, e.rd, e.alu, e.wr);
      end
      bus.memread  = 1'b0;
      bus.memwrite = 1'b0;
   endtask

   task automatic check_cleared(input string name);
      vectors++;
      if (bus.wb_ctlout !== 2'b00 || bus.read_data !== 32'h0 ||
          bus.mem_alu_result !== 32'h0 || bus.mem_write_reg !== 5'd0) begin
         miscompares++;
         $display("FAIL %s: wb=%b rd=%h alu=%h wr=%0d, required all zero", name,
                  bus.wb_ctlout, bus.read_data, bus.mem_alu_result, bus.mem_write_reg);
      end
   endtask

   task automatic test_reset();
      reset          = 1'b0;
      bus.memwrite   = 1'b1;
      bus.alu_result = 32'h10;
      bus.rdata2     = 32'h55;
      bus.branch     = 1'b1;
      bus.zero       = 1'b1;
      repeat (2) begin
         @(negedge clk);
         vectors++;
         if (bus.mem_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_stall: mem_stall=%b, required 0", bus.mem_stall);
         end
         @(posedge clk); #1;
      end
      check_cleared("reset_outputs");
      vectors++;
      if (bus.PCSrc !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_pcsrc: PCSrc=%b, required 1", bus.PCSrc);
      end
      bus.memwrite   = 1'b0;
      bus.branch     = 1'b0;
      bus.zero       = 1'b0;
      bus.alu_result = 32'h0;
      reset          = 1'b1;
      @(posedge clk); #1;
      issue(2'b11, 1'b1, 1'b0, 32'h10, 32'h0, 5'd3);
   endtask

   task automatic test_store_load();
      issue(2'b00, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 5'd0);
      issue(2'b11, 1'b1, 1'b0, 32'h10, 32'h0, 5'd7);
   endtask

   task automatic test_rtype();
      issue(2'b10, 1'b0, 1'b0, 32'd30, 32'h0, 5'd10);
   endtask

   task automatic test_branch();
      logic [2:0] tbl [3];
      tbl[0] = 3'b111;
      tbl[1] = 3'b100;
      tbl[2] = 3'b010;
      foreach (tbl[i]) begin
         bus.branch = tbl[i][2];
         bus.zero   = tbl[i][1];
         #1;
         vectors++;
         if (bus.PCSrc !== tbl[i][0]) begin
            miscompares++;
            $display("FAIL pcsrc b=%b z=%b: PCSrc=%b, required %b", tbl[i][2], tbl[i][1], bus.PCSrc, tbl[i][0]);
         end
      end
      bus.branch = 1'b0;
      bus.zero   = 1'b0;
   endtask

   task automatic test_reset_mid_access();
      bus.wb_ctl          = 2'b00;
      bus.memwrite        = 1'b1;
      bus.alu_result      = 32'h20;
      bus.rdata2          = 32'h1234;
      bus.five_bit_muxout = 5'd0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      vectors++;
      if (bus.mem_stall !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset_stall: mem_stall=%b, required 0", bus.mem_stall);
      end
      @(posedge clk); #1;
      bus.memwrite = 1'b0;
      reset        = 1'b1;
      check_cleared("midreset_outputs");
      issue(2'b10, 1'b0, 1'b0, 32'h4, 32'h0, 5'd2);
      issue(2'b11, 1'b1, 1'b0, 32'h20, 32'h0, 5'd4);
   endtask

   task automatic test_wrap_rbw();
      issue(2'b00, 1'b0, 1'b1, 32'h400, 32'hA5A5A5A5, 5'd0);
      issue(2'b11, 1'b1, 1'b0, 32'h0, 32'h0, 5'd5);
      issue(2'b11, 1'b1, 1'b1, 32'h0, 32'h1, 5'd6);
      issue(2'b11, 1'b1, 1'b0, 32'h0, 32'h0, 5'd8);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++)
         issue(2'b00, 1'b0, 1'b1, 32'h100 + 32'(i * 4), $urandom, 5'd0);
      for (int i = 0; i < 4; i++)
         issue(2'b11, 1'b1, 1'b0, 32'h100 + 32'(i * 4), 32'h0, 5'(i + 1));
      issue(2'b10, 1'b0, 1'b0, 32'h77, 32'h0, 5'd31);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      foreach (model[i]) model[i] = 32'h0;
      reset               = 1'b0;
      bus.wb_ctl          = 2'b00;
      bus.branch          = 1'b0;
      bus.memread         = 1'b0;
      bus.memwrite        = 1'b0;
      bus.zero            = 1'b0;
      bus.alu_result      = 32'h0;
      bus.rdata2          = 32'h0;
      bus.five_bit_muxout = 5'd0;
      @(posedge clk); #1;
      test_reset();
      test_store_load();
      test_rtype();
      test_branch();
      test_reset_mid_access();
      test_wrap_rbw();
      test_back_to_back();
      vectors++;
      if (sbq.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sbq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
